// File: rtl/key_event_fifo.sv
// Key event FIFO: buffers 16-bit Set-1 key words behind a data/status/control CPU window.
// Optional KEY_FIFO_TYPEMATIC_FILTER_EN drops repeated make codes (typematic repeat).
module key_event_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [15:0] BASE_ADDR  = 16'h0000
) (
    input  logic        global_clk,
    input  logic        global_rst_n,
    input  logic [15:0] key_data,
    input  logic        key_valid,
    input  logic [15:0] ram_addr,
    input  logic        ram_rd,
    input  logic        ram_wr,
    input  logic [15:0] ram_wdata,
    output logic [15:0] ram_data,
    output logic        key_irq
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned CW        = DEPTH_LOG2 + 1;
    localparam logic [15:0] DATA_ADDR = BASE_ADDR;
    localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;
    localparam logic [15:0] CTRL_ADDR = BASE_ADDR + 16'd2;

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
    logic [CW-1:0]         count, count_next;
    logic                  overflow, overflow_next;

    logic        full_c, empty_c, pop_c, push_c, flush_c;
    logic        ovf_clr_c, ovf_set_c, filt_c;
    logic [15:0] status_c, rd_word_c;
    logic        unused_wdata_c;

    assign unused_wdata_c = ^ram_wdata[15:2];

`ifdef KEY_FIFO_TYPEMATIC_FILTER_EN
    logic [15:0] last_pushed;

    // Most recent accepted word; a repeated make of it is typematic noise.
    always_ff @(posedge global_clk or negedge global_rst_n) begin
        if (!global_rst_n)  last_pushed <= 16'hFFFF;
        else if (flush_c)   last_pushed <= 16'hFFFF;
        else if (push_c)    last_pushed <= key_data;
    end

    assign filt_c = key_valid && !key_data[15] && (key_data == last_pushed);
`else
    assign filt_c = 1'b0;
`endif

    // Push/pop arbitration and next-state computation.
    always_comb begin
        full_c        = (count == CW'(DEPTH));
        empty_c       = (count == '0);
        flush_c       = ram_wr && (ram_addr == CTRL_ADDR) && ram_wdata[1];
        ovf_clr_c     = ram_wr && (ram_addr == CTRL_ADDR) && ram_wdata[0];
        pop_c         = ram_rd && (ram_addr == DATA_ADDR) && !empty_c;
        push_c        = key_valid && !filt_c && (!full_c || pop_c) && !flush_c;
        ovf_set_c     = key_valid && !filt_c && full_c && !pop_c;
        overflow_next = ovf_set_c ? 1'b1 : (ovf_clr_c ? 1'b0 : overflow);
        if (flush_c) begin
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
        end else begin
            count_next  = count + CW'(push_c) - CW'(pop_c);
            rd_ptr_next = rd_ptr + DEPTH_LOG2'(pop_c);
            wr_ptr_next = wr_ptr + DEPTH_LOG2'(push_c);
        end
        status_c  = {overflow, full_c, empty_c, 13'h0000} | 16'(count);
        rd_word_c = empty_c ? 16'h0000 : mem[rd_ptr];
    end

    // Storage has no reset; it is only visible through a non-empty read.
    always_ff @(posedge global_clk) begin
        if (push_c) mem[wr_ptr] <= key_data;
    end

    always_ff @(posedge global_clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            key_irq  <= 1'b0;
            ram_data <= 16'h0000;
        end else begin
            rd_ptr   <= rd_ptr_next;
            wr_ptr   <= wr_ptr_next;
            count    <= count_next;
            overflow <= overflow_next;
            key_irq  <= (count_next != '0);
            if (ram_rd) begin
                case (ram_addr)
                    DATA_ADDR: ram_data <= rd_word_c;
                    STAT_ADDR: ram_data <= status_c;
                    default:   ram_data <= 16'h0000;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_event_fifo.sv
// Self-checking bench for key_event_fifo using a queue scoreboard of accepted key words.
module tb_key_event_fifo;

    localparam int unsigned DEPTH = 16;
    localparam logic [15:0] BASE  = 16'h0000;

    logic        global_clk = 1'b0;
    logic        global_rst_n;
    logic [15:0] key_data, ram_addr, ram_wdata, ram_data;
    logic        key_valid, ram_rd, ram_wr, key_irq;

    int errors = 0;
    int checks = 0;

    logic [15:0] sb [$];
    logic        m_ovf  = 1'b0;
    logic [15:0] m_last = 16'hFFFF;

    key_event_fifo dut (
        .global_clk  (global_clk),
        .global_rst_n(global_rst_n),
        .key_data    (key_data),
        .key_valid   (key_valid),
        .ram_addr    (ram_addr),
        .ram_rd      (ram_rd),
        .ram_wr      (ram_wr),
        .ram_wdata   (ram_wdata),
        .ram_data    (ram_data),
        .key_irq     (key_irq)
    );

    always #5 global_clk = ~global_clk;

    task automatic tick();
        @(posedge global_clk);
        #1;
    endtask

    function automatic void m_push(input logic [15:0] w);
`ifdef KEY_FIFO_TYPEMATIC_FILTER_EN
        if (!w[15] && w == m_last) return;
`endif
        if (sb.size() == DEPTH) m_ovf = 1'b1;
        else begin
            sb.push_back(w);
            m_last = w;
        end
    endfunction

    function automatic logic [15:0] m_status();
        return {m_ovf, sb.size() == DEPTH, sb.size() == 0, 13'h0000} | 16'(sb.size());
    endfunction

    function automatic void m_flush();
        sb.delete();
        m_last = 16'hFFFF;
    endfunction

    task automatic push(input logic [15:0] w);
        key_data  = w;
        key_valid = 1'b1;
        m_push(w);
        tick();
        key_valid = 1'b0;
    endtask

    task automatic read_reg(input logic [15:0] a, output logic [15:0] d);
        ram_addr = a;
        ram_rd   = 1'b1;
        tick();
        ram_rd   = 1'b0;
        d        = ram_data;
    endtask

    task automatic write_ctrl(input logic [15:0] a, input logic [15:0] v);
        ram_addr  = a;
        ram_wdata = v;
        ram_wr    = 1'b1;
        tick();
        ram_wr    = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        global_rst_n = 1'b0;
        key_valid = 0; key_data = 0; ram_rd = 0; ram_wr = 0; ram_addr = 0; ram_wdata = 0;
        tick(); tick();
        checks++;
        if (ram_data !== 16'h0000 || key_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ram_data=%h key_irq=%b, want 0000/0", ram_data, key_irq);
        end
        global_rst_n = 1'b1;
        tick();
        read_reg(BASE + 16'd1, d);
        checks++;
        if (d !== 16'h2000) begin
            errors++;
            $display("FAIL reset_status: got %h want 2000", d);
        end
    endtask

    task automatic test_single();
        logic [15:0] d;
        push(16'h001E);
        checks++;
        if (key_irq !== 1'b1) begin
            errors++;
            $display("FAIL single_irq_high: got %b want 1", key_irq);
        end
        read_reg(BASE, d);
        checks++;
        if (d !== sb.pop_front() || d !== 16'h001E) begin
            errors++;
            $display("FAIL single_data: got %h want 001e", d);
        end
        checks++;
        if (key_irq !== 1'b0) begin
            errors++;
            $display("FAIL single_irq_drop: got %b want 0", key_irq);
        end
        read_reg(BASE + 16'd1, d);
        checks++;
        if (d !== 16'h2000) begin
            errors++;
            $display("FAIL single_status: got %h want 2000", d);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] d, e;
        for (int i = 0; i < 17; i++) push(16'h0100 + 16'(i));
        read_reg(BASE + 16'd1, d);
        checks++;
        if (d !== 16'hC010 || d !== m_status()) begin
            errors++;
            $display("FAIL ovf_status: got %h want c010", d);
        end
        for (int i = 0; i < 16; i++) begin
            read_reg(BASE, d);
            e = sb.pop_front();
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL ovf_drain[%0d]: got %h want %h", i, d, e);
            end
        end
        read_reg(BASE, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL ovf_empty_read: got %h want 0000", d);
        end
        read_reg(BASE + 16'd1, d);
        checks++;
        if (d !== 16'hA000) begin
            errors++;
            $display("FAIL ovf_sticky: got %h want a000", d);
        end
        write_ctrl(BASE + 16'd2, 16'h0001);
        m_ovf = 1'b0;
        read_reg(BASE + 16'd1, d);
        checks++;
        if (d !== 16'h2000) begin
            errors++;
            $display("FAIL ovf_clear: got %h want 2000", d);
        end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] d, e;
        for (int i = 0; i < 16; i++) push(16'h0200 + 16'(i));
        key_data  = 16'h02AA;
        key_valid = 1'b1;
        e = sb.pop_front();
        m_push(16'h02AA);
        read_reg(BASE, d);
        key_valid = 1'b0;
        checks++;
        if (d !== e || d !== 16'h0200) begin
            errors++;
            $display("FAIL full_pp_data: got %h want %h", d, e);
        end
        read_reg(BASE + 16'd1, d);
        checks++;
        if (d !== 16'h4010) begin
            errors++;
            $display("FAIL full_pp_status: got %h want 4010", d);
        end
        for (int i = 0; i < 16; i++) begin
            read_reg(BASE, d);
            e = sb.pop_front();
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL full_pp_drain[%0d]: got %h want %h", i, d, e);
            end
        end
        checks++;
        if (e !== 16'h02AA) begin
            errors++;
            $display("FAIL full_pp_last: got %h want 02aa", e);
        end
    endtask

    task automatic test_flush();
        logic [15:0] d;
        for (int i = 0; i < 17; i++) push(16'h0300 + 16'(i));
        for (int i = 0; i < 11; i++) begin
            read_reg(BASE, d);
            void'(sb.pop_front());
        end
        read_reg(BASE + 16'd1, d);
        checks++;
        if (d !== 16'h8005 || d !== m_status()) begin
            errors++;
            $display("FAIL flush_pre_status: got %h want 8005", d);
        end
        write_ctrl(BASE + 16'd2, 16'h0003);
        m_flush();
        m_ovf = 1'b0;
        checks++;
        if (key_irq !== 1'b0) begin
            errors++;
            $display("FAIL flush_irq: got %b want 0", key_irq);
        end
        read_reg(BASE + 16'd1, d);
        checks++;
        if (d !== 16'h2000) begin
            errors++;
            $display("FAIL flush_status: got %h want 2000", d);
        end
        // Flush racing a push: the push is discarded.
        key_data  = 16'h0399;
        key_valid = 1'b1;
        write_ctrl(BASE + 16'd2, 16'h0002);
        key_valid = 1'b0;
        read_reg(BASE + 16'd1, d);
        checks++;
        if (d !== 16'h2000) begin
            errors++;
            $display("FAIL flush_vs_push: got %h want 2000", d);
        end
    endtask

    task automatic test_empty_push_pop();
        logic [15:0] d;
        key_data  = 16'h0444;
        key_valid = 1'b1;
        m_push(16'h0444);
        read_reg(BASE, d);
        key_valid = 1'b0;
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL empty_pp_data: got %h want 0000", d);
        end
        checks++;
        if (key_irq !== 1'b1) begin
            errors++;
            $display("FAIL empty_pp_irq: got %b want 1", key_irq);
        end
        read_reg(BASE + 16'd3, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL other_addr_read: got %h want 0000", d);
        end
        write_ctrl(BASE + 16'd3, 16'h0003);
        read_reg(BASE + 16'd1, d);
        checks++;
        if (d !== 16'h0001 || d !== m_status()) begin
            errors++;
            $display("FAIL other_addr_write: got %h want 0001", d);
        end
        tick(); tick();
        checks++;
        if (ram_data !== 16'h0001) begin
            errors++;
            $display("FAIL hold_data: got %h want 0001", ram_data);
        end
        read_reg(BASE, d);
        checks++;
        if (d !== sb.pop_front()) begin
            errors++;
            $display("FAIL empty_pp_later: got %h want 0444", d);
        end
    endtask

    task automatic test_typematic();
        logic [15:0] d, e;
        logic [15:0] words [5] = '{16'h001E, 16'h001E, 16'h001E, 16'h801E, 16'h001E};
        write_ctrl(BASE + 16'd2, 16'h0003);
        m_flush();
        m_ovf = 1'b0;
        foreach (words[i]) push(words[i]);
        read_reg(BASE + 16'd1, d);
        checks++;
`ifdef KEY_FIFO_TYPEMATIC_FILTER_EN
        if (d !== 16'h0003) begin
            errors++;
            $display("FAIL typematic_count: got %h want 0003", d);
        end
`else
        if (d !== 16'h0005) begin
            errors++;
            $display("FAIL typematic_count: got %h want 0005", d);
        end
`endif
        while (sb.size() != 0) begin
            read_reg(BASE, d);
            e = sb.pop_front();
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL typematic_drain: got %h want %h", d, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        push(16'h0501);
        push(16'h0502);
        key_data     = 16'h0503;
        key_valid    = 1'b1;
        #2;
        global_rst_n = 1'b0;
        #1;
        checks++;
        if (key_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: key_irq=%b want 0", key_irq);
        end
        tick();
        key_valid    = 1'b0;
        global_rst_n = 1'b1;
        m_flush();
        m_ovf = 1'b0;
        read_reg(BASE + 16'd1, d);
        checks++;
        if (d !== 16'h2000) begin
            errors++;
            $display("FAIL reset_mid_status: got %h want 2000", d);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_empty_push_pop();
        test_typematic();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
